event_encoder8x3: RTL and testbench

Sequential 8-to-3 event encoder: the inverse of the 3-to-8 decoder used elsewhere in the decoders library. It captures single-cycle events on eight one-hot-position lines into a pending register. It emits one 3-bit index at a time, highest index first, over a valid/ready handshake. It sits between peripheral event sources and a consumer that decodes the index back into a one-hot select with the team's 3x8 decoder, so code `i` always corresponds to line `d[i]`/`ev[i]`.

---
 rtl/enc_pkg.sv | 24 ++
 rtl/event_encoder8x3_prio.sv | 16 +
 rtl/event_encoder8x3.sv | 110 +++++++++++
 tb/tb_event_encoder8x3.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared types and helpers for the 8-to-3 event encoder.
package enc_pkg;

  localparam int N  = 8;
  localparam int AW = 3;

  typedef logic [N-1:0]  ev_vec_t;
  typedef logic [AW-1:0] code_t;

  // Index of the highest set bit; 0 when no bit is set.
  function automatic code_t hi_index(input ev_vec_t vec);
    code_t idx;
    idx = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (vec[i]) begin
        idx = code_t'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/event_encoder8x3_prio.sv
// Combinational highest-set-bit encoder producing {any, idx}.
module prio_enc8x3
  import enc_pkg::*;
(
  input  logic [7:0] vec,
  output logic       any,
  output logic [2:0] idx
);

  // Flag and index of the highest set bit.
  always_comb begin
    any = |vec;
    idx = hi_index(vec);
  end

endmodule

// File: rtl/event_encoder8x3.sv
// Sequential 8-to-3 event encoder: captures events into a pending register and
// emits one index per valid/ready transfer. Define ENC_RR_EN for round-robin priority.
module event_encoder8x3 #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [N-1:0]  ev,
  input  logic          ready,
  output logic          valid,
  output logic [AW-1:0] code,
  output logic [N-1:0]  pending,
  output logic          overflow
);

  import enc_pkg::*;

  ev_vec_t pend_r;
  logic    valid_r;
  code_t   code_r;
  logic    ovf_r;

  ev_vec_t cap_s;
  ev_vec_t clr_s;
  ev_vec_t pend_nxt_s;
  ev_vec_t srch_s;
  logic    any_s;
  logic    free_s;
  logic    load_s;
  code_t   idx_s;
  code_t   sel_s;

  prio_enc8x3 u_prio (
    .vec (srch_s),
    .any (any_s),
    .idx (idx_s)
  );

`ifdef ENC_RR_EN
  code_t ptr_r;

  // Rotate pending so that bit ptr lands at position 7, then map the winner back.
  always_comb begin
    srch_s = 8'h00;
    for (int j = 0; j < N; j++) begin
      srch_s[j] = pend_r[code_t'(j) + ptr_r + 3'd1];
    end
    sel_s = idx_s + ptr_r + 3'd1;
  end

  // Search pointer moves just below the last loaded index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 3'd7;
    end else if (load_s) begin
      ptr_r <= sel_s - 3'd1;
    end else begin
      ptr_r <= ptr_r;
    end
  end
`else
  assign srch_s = pend_r;
  assign sel_s  = idx_s;
`endif

  // Stage freedom, load decision, and the clear/capture merge (set wins over clear).
  always_comb begin
    free_s = ~valid_r | ready;
    load_s = free_s & any_s;
    clr_s  = 8'h00;
    if (load_s) begin
      clr_s[sel_s] = 1'b1;
    end else begin
      clr_s = 8'h00;
    end
    cap_s      = en ? ev : 8'h00;
    pend_nxt_s = (pend_r & ~clr_s) | cap_s;
  end

  // Pending, output stage and overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_r  <= 8'h00;
      valid_r <= 1'b0;
      code_r  <= 3'd0;
      ovf_r   <= 1'b0;
    end else begin
      pend_r <= pend_nxt_s;
      ovf_r  <= |(cap_s & pend_r & ~clr_s);
      if (load_s) begin
        valid_r <= 1'b1;
        code_r  <= sel_s;
      end else if (free_s) begin
        valid_r <= 1'b0;
        code_r  <= code_r;
      end else begin
        valid_r <= valid_r;
        code_r  <= code_r;
      end
    end
  end

  assign valid    = valid_r;
  assign code     = code_r;
  assign pending  = pend_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_event_encoder8x3.sv
// Directed, table-driven bench for event_encoder8x3 (default fixed-priority build;
// a round-robin sequence replaces the table when ENC_RR_EN is defined).
module tb_event_encoder8x3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] ev;
  logic       ready;
  logic       valid;
  logic [2:0] code;
  logic [7:0] pending;
  logic       overflow;

  int total;
  int passed;

  typedef struct {
    logic [7:0] ev;
    logic       en;
    logic       rdy;
    logic       v;
    logic [2:0] c;
    logic [7:0] p;
    logic       o;
  } row_t;

  row_t tbl [33];

  event_encoder8x3 dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .ev       (ev),
    .ready    (ready),
    .valid    (valid),
    .code     (code),
    .pending  (pending),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [2:0] c,
                         input logic [7:0] p, input logic o);
    chk({tag, ".valid"}, int'(valid), int'(v));
    chk({tag, ".code"}, int'(code), int'(c));
    chk({tag, ".pending"}, int'(pending), int'(p));
    chk({tag, ".overflow"}, int'(overflow), int'(o));
  endtask

  function automatic row_t mk(input logic [7:0] e, input logic n, input logic r,
                              input logic v, input logic [2:0] c, input logic [7:0] p,
                              input logic o);
    row_t x;
    x.ev = e; x.en = n; x.rdy = r; x.v = v; x.c = c; x.p = p; x.o = o;
    return x;
  endfunction

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b1;
    en     = 1'b1;
    ev     = 8'hFF;
    ready  = 1'b0;

    // Reset with all events asserted.
    #2 rst_n = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rel_e1.valid", int'(valid), 0);
    chk("rel_e1.pending", int'(pending), 8'hFF);
    step();
    chk("rel_e2.valid", int'(valid), 1);
    chk("rel_e2.code", int'(code), 7);

    // Reset mid-transfer drops pending and presented code.
    ev = 8'h00;
    rst_n = 1'b0;
    #1;
    chk_all("midrst", 1'b0, 3'd0, 8'h00, 1'b0);
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("post_rst.valid", int'(valid), 0);
      chk("post_rst.pending", int'(pending), 0);
    end

`ifdef ENC_RR_EN
    ready = 1'b1;
    ev    = 8'b1000_0001;
    step();
    chk("rr_cap.pending", int'(pending), 8'h81);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("rr.valid", int'(valid), 1);
      chk("rr.code", int'(code), (k % 2 == 0) ? 7 : 0);
    end
    ev = 8'h00;
`else
    // ev pulse 0x25 drained with ready high.
    tbl[0]  = mk(8'h25, 1'b1, 1'b1, 1'b0, 3'd0, 8'h25, 1'b0);
    tbl[1]  = mk(8'h00, 1'b1, 1'b1, 1'b1, 3'd5, 8'h05, 1'b0);
    tbl[2]  = mk(8'h00, 1'b1, 1'b1, 1'b1, 3'd2, 8'h01, 1'b0);
    tbl[3]  = mk(8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
    tbl[4]  = mk(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    // Code 3 held against ready low, then one transfer.
    tbl[5]  = mk(8'h08, 1'b1, 1'b0, 1'b0, 3'd0, 8'h08, 1'b0);
    tbl[6]  = mk(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    tbl[7]  = mk(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    tbl[8]  = mk(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    tbl[9]  = mk(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 8'h00, 1'b0);
    tbl[10] = mk(8'h00, 1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0);
    // Overflow on bit 4 while code 6 is blocked.
    tbl[11] = mk(8'h40, 1'b1, 1'b0, 1'b0, 3'd3, 8'h40, 1'b0);
    tbl[12] = mk(8'h10, 1'b1, 1'b0, 1'b1, 3'd6, 8'h10, 1'b0);
    tbl[13] = mk(8'h10, 1'b1, 1'b0, 1'b1, 3'd6, 8'h10, 1'b1);
    tbl[14] = mk(8'h00, 1'b1, 1'b0, 1'b1, 3'd6, 8'h10, 1'b0);
    tbl[15] = mk(8'h00, 1'b1, 1'b1, 1'b1, 3'd4, 8'h00, 1'b0);
    tbl[16] = mk(8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    // en gating, then a one-cycle enable yields 7..0.
    tbl[17] = mk(8'hFF, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    tbl[18] = mk(8'hFF, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0);
    tbl[19] = mk(8'hFF, 1'b1, 1'b1, 1'b0, 3'd4, 8'hFF, 1'b0);
    tbl[20] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd7, 8'h7F, 1'b0);
    tbl[21] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd6, 8'h3F, 1'b0);
    tbl[22] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd5, 8'h1F, 1'b0);
    tbl[23] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd4, 8'h0F, 1'b0);
    tbl[24] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd3, 8'h07, 1'b0);
    tbl[25] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd2, 8'h03, 1'b0);
    tbl[26] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd1, 8'h01, 1'b0);
    tbl[27] = mk(8'hFF, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
    tbl[28] = mk(8'hFF, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);
    // Event re-arriving on the bit being cleared re-pends without overflow.
    tbl[29] = mk(8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 1'b0);
    tbl[30] = mk(8'h01, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 1'b0);
    tbl[31] = mk(8'h00, 1'b1, 1'b1, 1'b1, 3'd0, 8'h00, 1'b0);
    tbl[32] = mk(8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0);

    for (int i = 0; i < 33; i++) begin
      ev    = tbl[i].ev;
      en    = tbl[i].en;
      ready = tbl[i].rdy;
      step();
      chk_all($sformatf("row%0d", i), tbl[i].v, tbl[i].c, tbl[i].p, tbl[i].o);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
